tt_characterizer: RTL and testbench
===================================

# tt_characterizer

Sequential truth-table extractor for synthesized combinational gate netlists. Sweeps every input vector through an attached N_IN-input, 1-output gate under characterization (GUC) and assembles the function's truth table. It also compares the result against an expected table. Sits between the gate-level netlist harness and the design-flow checker, and converts a netlist back into the hex truth-table form it was synthesized from (e.g. 0x1FDE).

## Interface
- N_IN, 4, number of GUC inputs; truth-table width is 2**N_IN
- SETTLE, 2, extra cycles each vector is held before sampling (0..15)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a sweep; accepted only in IDLE
- abort  input  1  cancel a sweep in progress
- expected_tt  input  2**N_IN  reference table, registered when start is accepted
- guc_in  output  N_IN  vector driven to GUC; bit 0 drives the GUC's input _0 (LSB)
- guc_out  input  1  GUC output
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse, sweep complete
- tt  output  2**N_IN  extracted table; bit i = f(guc_in == i)
- tt_valid  output  1  tt holds a complete sweep result
- match  output  1  tt == registered expected_tt; meaningful only while tt_valid

## Operation
- States: IDLE, SWEEP.
- IDLE: guc_in = 0, busy = 0. If start is 1, the block:
  - registers expected_tt,
  - clears idx, settle count, tt, tt_valid and match,
  - goes to SWEEP.
- SWEEP:
  - guc_in = idx; busy = 1.
  - The settle counter counts 0..SETTLE.
  - At the edge where count == SETTLE, it writes guc_out into tt[idx], increments idx and resets the count.
  - At the capture of idx == 2**N_IN−1, it goes to IDLE and, on the same edge, sets tt_valid = 1, done = 1 and match = (final tt == expected).
- abort in SWEEP: go to IDLE on the next edge. tt_valid stays 0, no done pulse, partial tt is retained but invalid. abort in IDLE is ignored.
- abort and the final capture on the same edge: abort wins, no done.
- start while busy is ignored. start and abort together in IDLE: start is accepted.
- Asynchronous reset, including mid-sweep: state IDLE; guc_in, tt, idx, count, expected register = 0; busy, done, tt_valid, match = 0.
- After a sweep, tt, tt_valid and match hold until the next accepted start or reset.

## Timing
- Let E0 be the edge that accepts start. guc_in = 0 and busy = 1 from E0.
- Each vector is held for SETTLE+1 cycles. Vector i is captured at edge E((i+1)·(SETTLE+1)).
- Final capture is at E(2**N_IN·(SETTLE+1)); for the defaults this is E48.
- done and tt_valid are high, and busy is low, in the cycle after the final capture; done drops one edge later.
- Back-to-back sweeps: start high during the done cycle is accepted (state is IDLE).
- guc_in changes only on edges, so the GUC gets SETTLE+1 full cycles of combinational settling per vector.
- Throughput: one table per 2**N_IN·(SETTLE+1)+1 cycles with start held high.

## Test plan
- GUC modelled as f = bit (guc_in) of 0x1FDE, defaults, expected_tt = 0x1FDE, pulse start → guc_in steps 0..15 every 3 cycles; done at E48; tt = 0x1FDE, tt_valid = 1, match = 1.
- Same GUC, expected_tt = 0x1FDF → tt = 0x1FDE, match = 0; constant-0 GUC → tt = 0x0000; constant-1 GUC → tt = 0xFFFF.
- SETTLE = 0, identity GUC f = guc_in[0] → tt = 0xAAAA, done exactly 16 cycles after the start edge.
- abort asserted when idx = 7 → busy drops at next edge, no done, tt_valid = 0, guc_in = 0; a following start gives a full correct sweep.
- rst_n pulsed low mid-sweep (idx = 9) → all outputs 0 immediately, asynchronously; start re-asserted during busy is ignored (done still at E48 of the original sweep).
- start held high continuously → sweeps repeat every 49 cycles, with done pulsed once per sweep and tt_valid low between the accept edge and the completion edge.

Source files
------------

// File: rtl/tt_characterizer.sv
// Truth-table extractor: sweeps every input vector through an attached combinational
// gate, samples its output after a settle window and compares the table with a reference.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | guc_in parked at 0; waits for start; holds last result
// S_SWEEP | drives idx to the gate, captures one table bit per vector
module tt_characterizer #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected_tt,
    output logic [N_IN-1:0]      guc_in,
    input  logic                 guc_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   tt,
    output logic                 tt_valid,
    output logic                 match
);
    localparam int TW = 2**N_IN;
    localparam logic [0:0]      S_IDLE   = 1'b0;
    localparam logic [0:0]      S_SWEEP  = 1'b1;
    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

    logic [0:0]      state;
    logic [N_IN-1:0] idx;
    logic [3:0]      cnt;
    logic [TW-1:0]   exp_q;
    logic [TW-1:0]   tt_next;

    // Table as it will look after this cycle's capture; used for the final compare.
    always_comb begin
        tt_next      = tt;
        tt_next[idx] = guc_out;
    end

    assign busy   = (state == S_SWEEP);
    assign guc_in = (state == S_SWEEP) ? idx : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            exp_q    <= '0;
            tt       <= '0;
            tt_valid <= 1'b0;
            match    <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        exp_q    <= expected_tt;
                        idx      <= '0;
                        cnt      <= '0;
                        tt       <= '0;
                        tt_valid <= 1'b0;
                        match    <= 1'b0;
                        state    <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    // abort takes priority over a coinciding final capture
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (cnt == SETTLE_C) begin
                        tt  <= tt_next;
                        idx <= idx + 1'b1;
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state    <= S_IDLE;
                            tt_valid <= 1'b1;
                            done     <= 1'b1;
                            match    <= (tt_next == exp_q);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tt_characterizer.sv
// Self-checking bench for tt_characterizer: table-driven sweeps, random functions against
// a truth-table reference, and hand-written abort / reset / back-to-back sequences.
module tb_tt_characterizer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [15:0] expected_tt = '0;
    logic [3:0]  guc_in;
    logic        guc_out;
    logic        busy, done, tt_valid, match;
    logic [15:0] tt;
    logic [15:0] gfunc = '0;

    logic        start0 = 1'b0;
    logic [15:0] expected0 = '0;
    logic [3:0]  guc_in0;
    logic        busy0, done0, tt_valid0, match0;
    logic [15:0] tt0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign guc_out = gfunc[guc_in];

    tt_characterizer #(.N_IN(4), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .expected_tt(expected_tt), .guc_in(guc_in), .guc_out(guc_out),
        .busy(busy), .done(done), .tt(tt), .tt_valid(tt_valid), .match(match)
    );

    tt_characterizer #(.N_IN(4), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0),
        .expected_tt(expected0), .guc_in(guc_in0), .guc_out(guc_in0[0]),
        .busy(busy0), .done(done0), .tt(tt0), .tt_valid(tt_valid0), .match(match0)
    );

    typedef struct {
        string       name;
        logic [15:0] func;
        logic [15:0] exp_in;
        logic [15:0] tt_req;
        logic        match_req;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // One full sweep on the SETTLE=2 instance; vector i is held for 3 cycles.
    task automatic sweep(input string nm, input logic [15:0] f, input logic [15:0] e,
                         input logic [15:0] tt_req, input logic m_req, input int restart_at);
        int cyc;
        @(negedge clk);
        gfunc = f; expected_tt = e; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            if (cyc < 48)
                chk({nm, "/busy_guc_in"}, 32'({busy, guc_in}), 32'({1'b1, 4'(cyc / 3)}));
            if (done) break;
            start = (cyc == restart_at);
            expected_tt = start ? ~e : e;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        expected_tt = e;
        chk({nm, "/done_cycle"}, 32'(cyc), 32'd48);
        chk({nm, "/tt"}, 32'(tt), 32'(tt_req));
        chk({nm, "/valid_match_busy_guc"}, 32'({tt_valid, match, busy, guc_in}),
            32'({1'b1, m_req, 1'b0, 4'd0}));
        @(posedge clk); #1;
        chk({nm, "/done_drop"}, 32'({done, tt_valid, match}), 32'({1'b0, 1'b1, m_req}));
    endtask

    initial begin
        int cyc;
        int seen;
        logic [15:0] f, e;

        tbl[0] = '{"tt_1fde_match", 16'h1FDE, 16'h1FDE, 16'h1FDE, 1'b1};
        tbl[1] = '{"tt_1fde_nomatch", 16'h1FDE, 16'h1FDF, 16'h1FDE, 1'b0};
        tbl[2] = '{"const0", 16'h0000, 16'h1FDE, 16'h0000, 1'b0};
        tbl[3] = '{"const1", 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1};

        #23;
        chk("reset_outputs", 32'({busy, done, tt_valid, match, guc_in, tt}), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            sweep(tbl[i].name, tbl[i].func, tbl[i].exp_in, tbl[i].tt_req, tbl[i].match_req, -1);

        // Randomised functions: the extracted table is the function itself.
        for (int r = 0; r < 6; r++) begin
            f = 16'($urandom);
            e = ($urandom_range(0, 1) == 1) ? f : 16'($urandom);
            sweep("random", f, e, f, f == e, -1);
        end

        // SETTLE = 0 identity gate
        @(negedge clk);
        start0 = 1'b1; expected0 = 16'hAAAA;
        @(posedge clk); #1;
        start0 = 1'b0;
        cyc = 0;
        while (!done0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("settle0/done_cycle", 32'(cyc), 32'd16);
        chk("settle0/tt", 32'(tt0), 32'h0000AAAA);
        chk("settle0/valid_match", 32'({tt_valid0, match0, busy0}), 32'b110);

        // Abort at idx 7
        @(negedge clk);
        gfunc = 16'h1FDE; expected_tt = 16'h1FDE; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        chk("abort/idx7", 32'(guc_in), 32'd7);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort/outputs", 32'({busy, done, tt_valid, guc_in}), 32'd0);
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort/no_done", 32'(seen), 32'd0);
        f = 16'($urandom);
        sweep("after_abort", f, f, f, 1'b1, -1);

        // Asynchronous reset at idx 9, then start re-asserted while busy
        @(negedge clk);
        gfunc = 16'h1FDE; expected_tt = 16'h1FDE; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (27) @(posedge clk);
        #1;
        chk("reset_mid/idx9", 32'(guc_in), 32'd9);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("reset_mid/outputs", 32'({busy, done, tt_valid, match, guc_in, tt}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        sweep("start_while_busy", 16'h1FDE, 16'h1FDE, 16'h1FDE, 1'b1, 10);

        // start held high: a sweep every 49 cycles
        @(negedge clk);
        f = 16'($urandom);
        gfunc = f; expected_tt = f; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 150; k++) begin
            chk("continuous/done_valid", 32'({done, tt_valid}),
                (k % 49 == 48) ? 32'b11 : 32'b00);
            if (k % 49 == 48) chk("continuous/tt", 32'(tt), 32'(f));
            @(posedge clk); #1;
        end
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
